uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver. It deserializes one asynchronous serial line into parallel bytes using a 16x-baud sampling strobe from the baud tick generator. Sits between the board RX pin and the RX FIFO / interface logic. It reports each completed frame with a one-cycle done pulse and a framing-error flag.

## Interface

Parameters:
- DATA_BITS, 8, number of data bits per frame (LSB first).
- SB_TICK, 16, sampling ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2). Must be ≥ 8.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_tick  input  1  16x-baud sampling strobe, one i_clk cycle wide; all bit timing counts these strobes only.
- i_rx  input  1  asynchronous serial line, idle high.
- o_data  output  DATA_BITS  last received data word; holds until the next frame completes.
- o_rx_done  output  1  one-cycle pulse; o_data and o_frame_err are valid in the same cycle and afterwards.
- o_frame_err  output  1  1 when the stop bit of the last frame sampled low; updated only with o_rx_done.

## Operation

- **Input synchronizer:** i_rx passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value rx_s.
- **Internal counters:**
  - s: tick counter, 4 bits minimum, wide enough for SB_TICK-1.
  - n: bit counter, clog2(DATA_BITS) bits.
  - b: shift register, DATA_BITS wide.
  - stop_bit: 1-bit latch.
- **State IDLE:** if rx_s == 0, go to START and clear s. This transition does not wait for i_tick.
- **State START:** on i_tick:
  - If s == 7 and rx_s == 0: go to DATA, clear s and n (mid-bit confirmation).
  - If s == 7 and rx_s == 1: return to IDLE. This is glitch rejection; no output changes.
  - Otherwise s increments.
- **State DATA:** on i_tick:
  - If s == 15: clear s and shift b <= {rx_s, b[DATA_BITS-1:1]}, so the first bit received ends in b[0].
  - Then, if n == DATA_BITS-1, go to STOP; otherwise n increments.
  - Otherwise (s != 15), s increments.
- **Sampling point:** data bits are sampled 16 ticks apart, at the middle of each bit.
- **State STOP:** on i_tick:
  - At s == 7, latch stop_bit <= rx_s.
  - At s == SB_TICK-1, go to IDLE. In that same clock edge, o_data <= b, o_frame_err <= ~stop_bit, and o_rx_done <= 1.
  - Otherwise s increments.
- **Frame error handling:** a frame with a framing error still updates o_data.
- **o_rx_done:** is 0 in every other cycle.
- **Clocks without i_tick:** state, s, n and b hold, except for the IDLE→START transition.
- **Back-to-back frames:** supported. A start edge arriving in the first cycle back in IDLE is accepted.
- **Reset:** i_rst mid-frame aborts the frame. The partial word is discarded and no done pulse is produced.

## Timing

- Reset values:
  - o_data = 0, o_rx_done = 0, o_frame_err = 0.
  - State IDLE; s, n, b and stop_bit = 0.
  - Synchronizer flops = 1.
- Synchronizer latency: 2 clocks from an i_rx change to rx_s.
- Frame length: 8 + 16·DATA_BITS + SB_TICK ticks from entering START to o_rx_done, i.e. 152 ticks at the default parameters.
- o_rx_done is registered and asserts in the clock following the edge that samples the tick with s == SB_TICK-1.
- i_tick held high for consecutive clocks counts one tick per clock. No edge detection is performed.
- Outputs are registered only; there are no combinational paths from inputs to outputs.

## Test plan

- **Reset:** assert i_rst 3 cycles with i_rx = 1 → o_data = 0x00, o_rx_done = 0, o_frame_err = 0; no pulse over 500 idle cycles.
- **Basic frame:** i_tick every 4 clocks; send 0xA5 as 8N1, 16 ticks per bit → exactly one o_rx_done pulse, o_data = 0xA5, o_frame_err = 0; o_data holds 0xA5 for 200 cycles afterwards.
- **Glitch rejection:** drive i_rx low for 4 ticks, then high → receiver returns to IDLE, no o_rx_done. A following 0x3C frame is received correctly.
- **Framing error:** send 0x81 with the stop bit driven low → o_rx_done pulses, o_data = 0x81, o_frame_err = 1. The next valid frame 0x7E clears o_frame_err to 0.
- **Back-to-back frames:** send 0x00 then 0xFF with no idle gap → two pulses ≥ 160 ticks apart, values 0x00 then 0xFF, o_frame_err = 0 both times.
- **Reset mid-frame:** pulse i_rst during data bit 4 of 0x55 → no done pulse and o_data stays at its prior value. A subsequent 0xC3 frame is received intact.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop input synchronizer, start-bit mid-point
// confirmation, LSB-first data deserialization and stop-bit framing check.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICK   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err
);

  localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int N_W = ($clog2(DATA_BITS) > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [S_W-1:0]       s_q, s_d;
  logic [N_W-1:0]       n_q, n_d;
  logic [DATA_BITS-1:0] b_q, b_d;
  logic                 stop_bit_q, stop_bit_d;
  logic                 sync1_q, sync1_d;
  logic                 rx_s_q, rx_s_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      s_q        <= '0;
      n_q        <= '0;
      b_q        <= '0;
      stop_bit_q <= 1'b0;
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      n_q        <= n_d;
      b_q        <= b_d;
      stop_bit_q <= stop_bit_d;
      sync1_q    <= sync1_d;
      rx_s_q     <= rx_s_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    b_d        = b_q;
    stop_bit_d = stop_bit_q;
    sync1_d    = i_rx;
    rx_s_d     = sync1_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = ferr_q;

    case (state_q)
      // Start detection is immediate; every later step waits for a tick.
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (i_tick) begin
          if (s_q == S_W'(7)) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (s_q == S_W'(15)) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DATA_BITS-1:1]};
            if (n_q == N_W'(DATA_BITS - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (s_q == S_W'(7)) begin
            stop_bit_d = rx_s_q;
          end
          // A bad stop bit still publishes the word, flagged as a framing error.
          if (s_q == S_W'(SB_TICK - 1)) begin
            state_d = IDLE;
            data_d  = b_q;
            ferr_d  = ~stop_bit_q;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx: frames are driven as 16 ticks per
// bit and every done pulse is matched against a queue of expected words.
module tb_uart_rx;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       tick = 1'b0;
  logic       rx   = 1'b1;
  logic [7:0] data;
  logic       done;
  logic       ferr;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   pulse_cyc[$];

  uart_rx #(.DATA_BITS(8), .SB_TICK(16)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_tick     (tick),
    .i_rx       (rx),
    .o_data     (data),
    .o_rx_done  (done),
    .o_frame_err(ferr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle in which done is high.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      rec_t r;
      r.d  = data;
      r.fe = ferr;
      obs_q.push_back(r);
      pulse_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1(input logic t);
    @(posedge clk);
    #1 tick = t;
  endtask

  // One slot = 4 clocks with a single tick; the line changes mid-slot.
  task automatic drive(input logic v, input int nslots);
    for (int i = 0; i < nslots; i++) begin
      clk1(1'b0);
      clk1(1'b0);
      if (i == 0) rx = v;
      clk1(1'b0);
      clk1(1'b1);
    end
  endtask

  // Reference model: a frame yields its byte, flagged when the stop bit is low.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rec_t r;
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) drive(d[i], 16);
    drive(stop, 16);
    r.d  = d;
    r.fe = ~stop;
    exp_q.push_back(r);
  endtask

  task automatic chk_frames(input string tag);
    int n;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, 32'(obs_q[i].d), 32'(exp_q[i].d));
      chk({tag, "_ferr"}, 32'(obs_q[i].fe), 32'(exp_q[i].fe));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] v55;
    logic [7:0] rd;
    logic       rs;
    int         gap;

    // Reset
    rst = 1'b1;
    rx  = 1'b1;
    clk1(1'b0);
    clk1(1'b0);
    clk1(1'b0);
    rst = 1'b0;
    clk1(1'b0);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ferr", 32'(ferr), 32'h0);
    drive(1'b1, 125);
    chk("idle_nopulse", 32'(obs_q.size()), 32'd0);
    chk("idle_data", 32'(data), 32'h00);

    // Basic frame and hold
    send_frame(8'hA5, 1'b1);
    drive(1'b1, 4);
    chk_frames("basic");
    drive(1'b1, 50);
    chk("basic_hold", 32'(data), 32'hA5);
    chk("basic_nopulse", 32'(obs_q.size()), 32'd0);

    // Glitch rejection
    drive(1'b0, 4);
    drive(1'b1, 30);
    chk("glitch_nopulse", 32'(obs_q.size()), 32'd0);
    chk("glitch_hold", 32'(data), 32'hA5);
    send_frame(8'h3C, 1'b1);
    drive(1'b1, 4);
    chk_frames("glitch_next");

    // Framing error, then recovery
    send_frame(8'h81, 1'b0);
    drive(1'b1, 20);
    chk_frames("ferr");
    send_frame(8'h7E, 1'b1);
    drive(1'b1, 4);
    chk_frames("ferr_clear");

    // Back-to-back frames
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive(1'b1, 4);
    gap = (pulse_cyc.size() >= 2) ? (pulse_cyc[$] - pulse_cyc[$-1]) : 0;
    chk("b2b_gap_ok", 32'(gap >= 640), 32'd1);
    chk_frames("b2b");

    // Randomized frames, occasionally with a bad stop bit
    for (int k = 0; k < 6; k++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rs);
      drive(1'b1, 20);
    end
    chk_frames("rand");

    // Reset in the middle of data bit 4
    send_frame(8'h00, 1'b1);
    drive(1'b1, 4);
    chk_frames("pre_rst");
    v55 = 8'h55;
    drive(1'b0, 16);
    for (int i = 0; i < 4; i++) drive(v55[i], 16);
    drive(v55[4], 8);
    clk1(1'b0);
    rst = 1'b1;
    clk1(1'b0);
    clk1(1'b0);
    rst = 1'b0;
    drive(1'b1, 200);
    chk("midrst_nopulse", 32'(obs_q.size()), 32'd0);
    chk("midrst_data", 32'(data), 32'h00);
    chk("midrst_ferr", 32'(ferr), 32'h0);
    send_frame(8'hC3, 1'b1);
    drive(1'b1, 4);
    chk_frames("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
